// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared configuration for the ID-stage hazard/forwarding unit: widths,
// stall-cause encodings, boolean/zero constants and a saturating increment.
package hazard_scoreboard_unit_pkg;

    localparam int CFG_XLEN = 32;
    localparam int CFG_AW   = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [31:0] ZERO32     = 32'h0000_0000;
    localparam logic [31:0] ALL_ONES32 = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_LOAD_USE = 2'd1,
        CAUSE_BUSY     = 2'd2,
        CAUSE_FULL     = 2'd3
    } stall_cause_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == ALL_ONES32) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle of ID-stage, forwarding-stage and completion-bus signals exchanged
// with the hazard unit; the master drives the pipeline side.
interface hazard_scoreboard_unit_if
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int XLEN     = CFG_XLEN,
    parameter int AW       = CFG_AW,
    parameter int NRS      = 2,
    parameter int NSTG     = 3,
    parameter int LONG_MAX = 4
);
    localparam int CW = $clog2(LONG_MAX + 1);

    logic                 id_valid;
    logic [NRS-1:0]       id_rs_en;
    logic [NRS*AW-1:0]    id_rs_addr;
    logic [NRS*XLEN-1:0]  id_rs_data;
    logic                 id_rd_en;
    logic [AW-1:0]        id_rd_addr;
    logic                 id_long;
    logic                 flush;
    logic [NSTG-1:0]      fw_en;
    logic [NSTG-1:0]      fw_load;
    logic [NSTG*AW-1:0]   fw_addr;
    logic [NSTG*XLEN-1:0] fw_data;
    logic                 lc_valid;
    logic [AW-1:0]        lc_addr;
    logic [XLEN-1:0]      lc_data;

    logic [NRS*XLEN-1:0]  rs_out;
    logic                 stall;
    logic [1:0]           stall_cause;
    logic [CW-1:0]        long_cnt;
    logic [31:0]          stall_cycles;
    logic                 sb_err;

    modport master (
        output id_valid, id_rs_en, id_rs_addr, id_rs_data, id_rd_en, id_rd_addr,
               id_long, flush, fw_en, fw_load, fw_addr, fw_data,
               lc_valid, lc_addr, lc_data,
        input  rs_out, stall, stall_cause, long_cnt, stall_cycles, sb_err
    );

    modport slave (
        input  id_valid, id_rs_en, id_rs_addr, id_rs_data, id_rd_en, id_rd_addr,
               id_long, flush, fw_en, fw_load, fw_addr, fw_data,
               lc_valid, lc_addr, lc_data,
        output rs_out, stall, stall_cause, long_cnt, stall_cycles, sb_err
    );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_mux.sv
// Resolves one source operand: youngest matching stage wins, then the
// long-op completion bus, then the register file; flags a load-use hit.
module fwd_mux
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int XLEN = CFG_XLEN,
    parameter int AW   = CFG_AW,
    parameter int NSTG = 3
) (
    input  logic                 en_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic [NSTG-1:0]      fw_en_i,
    input  logic [NSTG-1:0]      fw_load_i,
    input  logic [NSTG*AW-1:0]   fw_addr_i,
    input  logic [NSTG*XLEN-1:0] fw_data_i,
    input  logic                 lc_valid_i,
    input  logic [AW-1:0]        lc_addr_i,
    input  logic [XLEN-1:0]      lc_data_i,
    output logic [XLEN-1:0]      data_o,
    output logic                 load_use_o
);

    logic            active_s;
    logic            hit_s;
    logic [XLEN-1:0] data_s;
    logic            load_use_s;

    // x0 is hard-wired zero, so it is never a forwarding or stall candidate
    assign active_s = en_i & (addr_i != {AW{1'b0}});

    // Walk stages oldest to youngest so the youngest match overwrites the rest
    always_comb begin
        hit_s      = FALSE;
        data_s     = '0;
        load_use_s = FALSE;
        if (active_s) begin
            data_s = (lc_valid_i && (lc_addr_i == addr_i)) ? lc_data_i : rf_data_i;
            for (int s = NSTG - 1; s >= 0; s--) begin
                hit_s      = fw_en_i[s] && (fw_addr_i[s*AW +: AW] == addr_i);
                data_s     = hit_s ? fw_data_i[s*XLEN +: XLEN] : data_s;
                load_use_s = hit_s ? fw_load_i[s] : load_use_s;
            end
        end else begin
            data_s     = '0;
            load_use_s = FALSE;
        end
    end

    assign data_o     = data_s;
    assign load_use_o = load_use_s;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage operand forwarding, long-latency register scoreboard, stall/cause
// generation and saturating stall-cycle counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int XLEN     = CFG_XLEN,
    parameter int AW       = CFG_AW,
    parameter int NRS      = 2,
    parameter int NSTG     = 3,
    parameter int LONG_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_scoreboard_unit_if.slave bus
);

    localparam int             CW         = $clog2(LONG_MAX + 1);
    localparam int             NREG       = 1 << AW;
    localparam logic [CW-1:0]  LONG_MAX_C = CW'(LONG_MAX);
    localparam logic [CW-1:0]  ONE_C      = CW'(1);
    localparam logic [AW-1:0]  X0_C       = {AW{1'b0}};

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   long_cnt_q, long_cnt_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;
    logic            sb_err_q, sb_err_d;

    logic [NRS-1:0]  load_use_s;
    logic [NRS-1:0]  busy_hit_s;
    logic            comp_s;
    logic            err_s;
    logic            waw_s;
    logic            full_s;
    logic            stall_s;
    logic            issue_s;
    logic            rd_live_s;
    stall_cause_e    cause_s;

    for (genvar k = 0; k < NRS; k++) begin : g_port
        logic [AW-1:0] addr_s;
        assign addr_s = bus.id_rs_addr[k*AW +: AW];

        fwd_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NSTG (NSTG)
        ) u_fwd_mux (
            .en_i       (bus.id_rs_en[k]),
            .addr_i     (addr_s),
            .rf_data_i  (bus.id_rs_data[k*XLEN +: XLEN]),
            .fw_en_i    (bus.fw_en),
            .fw_load_i  (bus.fw_load),
            .fw_addr_i  (bus.fw_addr),
            .fw_data_i  (bus.fw_data),
            .lc_valid_i (bus.lc_valid),
            .lc_addr_i  (bus.lc_addr),
            .lc_data_i  (bus.lc_data),
            .data_o     (bus.rs_out[k*XLEN +: XLEN]),
            .load_use_o (load_use_s[k])
        );

        // A same-cycle completion to this register is bypassed, so it is not a hazard
        assign busy_hit_s[k] = bus.id_rs_en[k] & (addr_s != X0_C) & busy_q[addr_s]
                             & ~(bus.lc_valid & (bus.lc_addr == addr_s));
    end

    assign rd_live_s = bus.id_rd_en & (bus.id_rd_addr != X0_C);
    assign comp_s    = bus.lc_valid &  busy_q[bus.lc_addr];
    assign err_s     = bus.lc_valid & ~busy_q[bus.lc_addr];
    assign waw_s     = rd_live_s & busy_q[bus.id_rd_addr]
                     & ~(bus.lc_valid & (bus.lc_addr == bus.id_rd_addr));
    // Only a completion that really frees a slot relieves a full queue; a stray
    // completion to an idle register must not let the counter pass LONG_MAX.
    assign full_s    = bus.id_long & (long_cnt_q == LONG_MAX_C) & ~comp_s;
    assign stall_s   = bus.id_valid & ~bus.flush
                     & ((|load_use_s) | (|busy_hit_s) | waw_s | full_s);
    assign issue_s   = bus.id_valid & bus.id_long & rd_live_s & ~stall_s & ~bus.flush;

    // Encode the highest-priority stall reason
    always_comb begin
        cause_s = CAUSE_NONE;
        if (!stall_s) begin
            cause_s = CAUSE_NONE;
        end else if (|load_use_s) begin
            cause_s = CAUSE_LOAD_USE;
        end else if ((|busy_hit_s) | waw_s) begin
            cause_s = CAUSE_BUSY;
        end else begin
            cause_s = CAUSE_FULL;
        end
    end

    // Scoreboard and counter next state; issue is applied after completion so a
    // same-address issue/complete pair leaves the register busy.
    always_comb begin
        busy_d                  = busy_q;
        busy_d[bus.lc_addr]     = comp_s  ? FALSE : busy_d[bus.lc_addr];
        busy_d[bus.id_rd_addr]  = issue_s ? TRUE  : busy_d[bus.id_rd_addr];
        case ({issue_s, comp_s})
            2'b10:   long_cnt_d = long_cnt_q + ONE_C;
            2'b01:   long_cnt_d = long_cnt_q - ONE_C;
            default: long_cnt_d = long_cnt_q;
        endcase
        stall_cycles_d = stall_s ? sat_inc32(stall_cycles_q) : stall_cycles_q;
        sb_err_d       = sb_err_q | err_s;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            long_cnt_q     <= '0;
            stall_cycles_q <= ZERO32;
            sb_err_q       <= FALSE;
        end else begin
            busy_q         <= busy_d;
            long_cnt_q     <= long_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            sb_err_q       <= sb_err_d;
        end
    end

    assign bus.stall        = stall_s;
    assign bus.stall_cause  = cause_s;
    assign bus.long_cnt     = long_cnt_q;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.sb_err       = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed scoreboard bench: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_scoreboard_unit;

    localparam int AW   = 5;
    localparam int XLEN = 32;

    localparam logic [5:0] M_R0 = 6'b100000;
    localparam logic [5:0] M_R1 = 6'b010000;
    localparam logic [5:0] M_ST = 6'b001000;
    localparam logic [5:0] M_CN = 6'b000100;
    localparam logic [5:0] M_SC = 6'b000010;
    localparam logic [5:0] M_ER = 6'b000001;

    typedef struct packed {
        logic [5:0]  m;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        st;
        logic [1:0]  cs;
        logic [2:0]  cn;
        logic [31:0] sc;
        logic        er;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t  exp_q[$];
    string nm_q[$];
    exp_t  mon_e;
    string mon_nm;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if bus ();

    hazard_scoreboard_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
        end
    endtask

    // Monitor: compare queued expectations against the outputs mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = nm_q.pop_front();
            if (mon_e.m[5]) chk(mon_nm, "rs0", bus.rs_out[31:0], mon_e.r0);
            if (mon_e.m[4]) chk(mon_nm, "rs1", bus.rs_out[63:32], mon_e.r1);
            if (mon_e.m[3]) begin
                chk(mon_nm, "stall", {31'd0, bus.stall}, {31'd0, mon_e.st});
                chk(mon_nm, "cause", {30'd0, bus.stall_cause}, {30'd0, mon_e.cs});
            end
            if (mon_e.m[2]) chk(mon_nm, "long_cnt", {29'd0, bus.long_cnt}, {29'd0, mon_e.cn});
            if (mon_e.m[1]) chk(mon_nm, "stall_cycles", bus.stall_cycles, mon_e.sc);
            if (mon_e.m[0]) chk(mon_nm, "sb_err", {31'd0, bus.sb_err}, {31'd0, mon_e.er});
        end
    end

    task automatic push_exp(input string nm, input logic [5:0] m, input logic [31:0] r0,
                            input logic [31:0] r1, input logic st, input logic [1:0] cs,
                            input logic [2:0] cn, input logic [31:0] sc, input logic er);
        exp_t e;
        e = '{m: m, r0: r0, r1: r1, st: st, cs: cs, cn: cn, sc: sc, er: er};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic set_idle();
        bus.id_valid   = 1'b0;
        bus.id_rs_en   = '0;
        bus.id_rs_addr = '0;
        bus.id_rs_data = '0;
        bus.id_rd_en   = 1'b0;
        bus.id_rd_addr = '0;
        bus.id_long    = 1'b0;
        bus.flush      = 1'b0;
        bus.fw_en      = '0;
        bus.fw_load    = '0;
        bus.fw_addr    = '0;
        bus.fw_data    = '0;
        bus.lc_valid   = 1'b0;
        bus.lc_addr    = '0;
        bus.lc_data    = '0;
    endtask

    task automatic src(input int k, input logic [4:0] a, input logic [31:0] d);
        bus.id_valid                = 1'b1;
        bus.id_rs_en[k]             = 1'b1;
        bus.id_rs_addr[k*AW +: AW]  = a;
        bus.id_rs_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic fwd(input int s, input logic [4:0] a, input logic [31:0] d, input logic ld);
        bus.fw_en[s]                = 1'b1;
        bus.fw_load[s]              = ld;
        bus.fw_addr[s*AW +: AW]     = a;
        bus.fw_data[s*XLEN +: XLEN] = d;
    endtask

    task automatic long_op(input logic [4:0] rd);
        bus.id_valid   = 1'b1;
        bus.id_long    = 1'b1;
        bus.id_rd_en   = 1'b1;
        bus.id_rd_addr = rd;
    endtask

    task automatic lc(input logic [4:0] a, input logic [31:0] d);
        bus.lc_valid = 1'b1;
        bus.lc_addr  = a;
        bus.lc_data  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    initial begin
        set_idle();
        push_exp("reset", M_R0|M_ST|M_CN|M_SC|M_ER, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0);
        @(posedge clk);
        step();
        rst_n = 1'b1;

        // EX beats MEM; disabled port 1 reads zero
        fwd(0, 5'd5, 32'h11, 1'b0); fwd(1, 5'd5, 32'h22, 1'b0);
        src(0, 5'd5, 32'hDEAD);
        bus.id_rs_addr[9:5] = 5'd5; bus.id_rs_data[63:32] = 32'h5555;
        push_exp("fwd_ex", M_R0|M_R1|M_ST|M_CN, 32'h11, 32'h0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0);
        step();
        src(0, 5'd6, 32'h66); src(1, 5'd8, 32'h88); fwd(2, 5'd8, 32'h33, 1'b0);
        push_exp("fwd_wb_rf", M_R0|M_R1|M_ST, 32'h66, 32'h33, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0);
        step();
        src(1, 5'd7, 32'h0); fwd(0, 5'd7, 32'hBAD, 1'b1); fwd(2, 5'd7, 32'h99, 1'b0);
        push_exp("load_use", M_ST|M_SC, 32'h0, 32'h0, 1'b1, 2'd1, 3'd0, 32'd0, 1'b0);
        step();
        src(1, 5'd7, 32'h0); fwd(1, 5'd7, 32'h77, 1'b0);
        push_exp("load_mem", M_R1|M_ST|M_SC, 32'h0, 32'h77, 1'b0, 2'd0, 3'd0, 32'd1, 1'b0);
        step();
        long_op(5'd9);
        push_exp("issue_x9", M_ST|M_CN|M_SC, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 32'd1, 1'b0);
        step();
        src(0, 5'd9, 32'h0);
        push_exp("busy_x9", M_ST|M_CN, 32'h0, 32'h0, 1'b1, 2'd2, 3'd1, 32'd1, 1'b0);
        step();
        src(0, 5'd9, 32'h0); lc(5'd9, 32'hABCD);
        push_exp("lc_bypass", M_R0|M_ST|M_CN|M_SC, 32'hABCD, 32'h0, 1'b0, 2'd0, 3'd1, 32'd2, 1'b0);
        step();
        src(0, 5'd9, 32'h1234);
        push_exp("x9_clear", M_R0|M_ST|M_CN, 32'h1234, 32'h0, 1'b0, 2'd0, 3'd0, 32'd2, 1'b0);
        step();
        long_op(5'd10);
        push_exp("issue_x10", M_ST|M_CN, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 32'd2, 1'b0);
        step();
        bus.id_valid = 1'b1; bus.id_rd_en = 1'b1; bus.id_rd_addr = 5'd10;
        push_exp("waw_x10", M_ST|M_CN|M_SC, 32'h0, 32'h0, 1'b1, 2'd2, 3'd1, 32'd2, 1'b0);
        step();
        long_op(5'd11);
        push_exp("issue_x11", M_ST|M_SC, 32'h0, 32'h0, 1'b0, 2'd0, 3'd1, 32'd3, 1'b0);
        step();
        long_op(5'd12);
        push_exp("issue_x12", M_CN, 32'h0, 32'h0, 1'b0, 2'd0, 3'd2, 32'd3, 1'b0);
        step();
        long_op(5'd13);
        push_exp("issue_x13", M_CN, 32'h0, 32'h0, 1'b0, 2'd0, 3'd3, 32'd3, 1'b0);
        step();
        long_op(5'd14);
        push_exp("full", M_ST|M_CN|M_SC, 32'h0, 32'h0, 1'b1, 2'd3, 3'd4, 32'd3, 1'b0);
        step();
        long_op(5'd14); lc(5'd10, 32'h1010);
        push_exp("full_relief", M_ST|M_CN|M_SC, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd4, 1'b0);
        step();
        long_op(5'd11); lc(5'd11, 32'h1111);
        push_exp("same_addr", M_ST|M_CN, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd4, 1'b0);
        step();
        src(0, 5'd11, 32'h0);
        push_exp("x11_still_busy", M_ST|M_CN|M_SC, 32'h0, 32'h0, 1'b1, 2'd2, 3'd4, 32'd4, 1'b0);
        step();
        lc(5'd3, 32'h3333);
        push_exp("stray_lc", M_CN|M_SC|M_ER, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd5, 1'b0);
        step();
        push_exp("sb_err_set", M_ST|M_CN|M_SC|M_ER, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd5, 1'b1);
        step();
        src(0, 5'd0, 32'h99); fwd(0, 5'd0, 32'hFF, 1'b1);
        push_exp("x0", M_R0|M_ST|M_ER, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd5, 1'b1);
        step();
        src(0, 5'd11, 32'h0); bus.flush = 1'b1;
        push_exp("flush", M_ST|M_SC, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd5, 1'b1);
        step();
        push_exp("after_flush", M_CN|M_SC, 32'h0, 32'h0, 1'b0, 2'd0, 3'd4, 32'd5, 1'b1);
        step();
        src(0, 5'd12, 32'h0);
        push_exp("x12_busy", M_ST|M_SC, 32'h0, 32'h0, 1'b1, 2'd2, 3'd4, 32'd5, 1'b1);
        step();
        // Asynchronous reset asserted between edges
        push_exp("reset_mid", M_ST|M_CN|M_SC|M_ER, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0);
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        src(0, 5'd11, 32'h55);
        push_exp("post_reset", M_R0|M_ST|M_CN|M_SC, 32'h55, 32'h0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0);
        step();
        push_exp("post_idle", M_CN|M_SC|M_ER, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0);
        step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
